// File: rtl/grid_diff_scanner.sv
// Walks the cell grid, encodes object flags and presents cells that differ from the shadow frame
// (or every cell in full-refresh mode) over a diff/cmd_done handshake; one cell per cycle.
module grid_diff_scanner #(
  parameter  int GRID_W = 16,
  parameter  int GRID_H = 12,
  parameter  int CODE_W = 3,
  parameter  int CNT_W  = 8,
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              full_refresh,
  input  logic              snakeHead,
  input  logic              snakeBody,
  input  logic              apple,
  input  logic              border,
  input  logic              cmd_done,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [CODE_W-1:0] obj_code,
  output logic              diff,
  output logic              busy,
  output logic              init_cycle,
  output logic              frame_done,
  output logic [CNT_W-1:0]  diff_count
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IW    = $clog2(CELLS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                fr_q, fr_d;
  logic                init_q, init_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    dcount_q, dcount_d;
  logic [CODE_W-1:0]   shadow_q [CELLS];
  logic                shadow_we;

  logic [IW-1:0]       cell_idx;
  logic [CODE_W-1:0]   enc;
  logic [CODE_W-1:0]   shadow_rd;
  logic                at_xmax;
  logic                last_cell;
  logic [XW-1:0]       adv_x;
  logic [YW-1:0]       adv_y;

  assign cell_idx  = IW'(y_q) * IW'(GRID_W) + IW'(x_q);
  assign shadow_rd = shadow_q[cell_idx];
  assign at_xmax   = (x_q == XW'(GRID_W - 1));
  assign last_cell = at_xmax && (y_q == YW'(GRID_H - 1));
  assign adv_x     = at_xmax ? '0 : x_q + 1'b1;
  assign adv_y     = at_xmax ? y_q + 1'b1 : y_q;

  // Head outranks body so a snake eating an apple or touching the wall shows as the snake.
  always_comb begin
    enc = '0;
    if (snakeHead)      enc = CODE_W'(2);
    else if (snakeBody) enc = CODE_W'(1);
    else if (apple)     enc = CODE_W'(3);
    else if (border)    enc = CODE_W'(4);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    code_d    = code_q;
    fr_d      = fr_q;
    init_d    = init_q;
    cnt_d     = cnt_q;
    dcount_d  = dcount_q;
    shadow_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        x_d   = '0;
        y_d   = '0;
        cnt_d = '0;
        if (frame_start) begin
          fr_d    = full_refresh | init_q;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (fr_q || (enc != shadow_rd)) begin
          code_d  = enc;
          state_d = PRESENT;
        end else if (last_cell) begin
          x_d     = '0;
          y_d     = '0;
          state_d = DONE;
        end else begin
          x_d = adv_x;
          y_d = adv_y;
        end
      end
      PRESENT: begin
        if (cmd_done) begin
          shadow_we = 1'b1;
          cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (last_cell) begin
            x_d     = '0;
            y_d     = '0;
            state_d = DONE;
          end else begin
            x_d     = adv_x;
            y_d     = adv_y;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        dcount_d = cnt_q;
        init_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      code_q   <= '0;
      fr_q     <= 1'b0;
      init_q   <= 1'b1;
      cnt_q    <= '0;
      dcount_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      code_q   <= code_d;
      fr_q     <= fr_d;
      init_q   <= init_d;
      cnt_q    <= cnt_d;
      dcount_q <= dcount_d;
    end
  end

  // Register array so the whole shadow frame clears in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[cell_idx] <= code_q;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign obj_code   = code_q;
  assign diff       = (state_q == PRESENT);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign init_cycle = init_q;
  assign diff_count = dcount_q;

endmodule
